vrf_burst_master: RTL and testbench

- Initiator side of the single-port vector register-file RAM interface (req/we/addr/wdata, rdata registered one cycle after a read request).
- Accepts burst commands: base address, length, direction.
- Read bursts: issues consecutive read requests and streams the returned words out over a valid/ready port with backpressure.
- Write bursts: sinks a valid/ready stream and issues consecutive writes.
- Sits between the vector load/store unit and the RAM macro.

---
 rtl/vrf_burst_master.sv | 193 +++++++++++++++++++
 tb/tb_vrf_burst_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_burst_master.sv
// Burst initiator for the single-port vector register-file RAM: turns base/length/direction
// commands into RAM traffic. Define VRF_BURST_PERF_EN to add the stall counter perf_stall_cnt_o.
module vrf_burst_master #(
  parameter int Width  = 128,
  parameter int Depth  = 256,
  parameter int MaxLen = 16,
  localparam int AW = $clog2(Depth),
  localparam int LW = $clog2(MaxLen + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [AW-1:0]    cmd_addr_i,
  input  logic [LW-1:0]    cmd_len_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [Width-1:0] wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [Width-1:0] rd_data_o,
  output logic             done_o,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [AW-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic [Width-1:0] ram_rdata_i
`ifdef VRF_BURST_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    pop_cnt_q, pop_cnt_d;
  logic [Width-1:0] fifo_q [2];
  logic             wptr_q, rptr_q, inflight_q;
  logic [1:0]       count_q;
  logic             issue_s, pop_s, push_s, fifo_pop_s, wr_fire_s;
  logic [AW-1:0]    addr_inc_s;

  assign addr_inc_s = (addr_q == AW'(Depth - 1)) ? '0 : addr_q + AW'(1);

  // Next-state and output decode. Read data returning from the RAM bypasses an empty
  // FIFO so the first word is visible in the cycle it arrives.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    pop_cnt_d   = pop_cnt_q;
    cmd_ready_o = (state_q == ST_IDLE);
    wr_ready_o  = 1'b0;
    rd_valid_o  = 1'b0;
    rd_data_o   = '0;
    done_o      = 1'b0;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = addr_q;
    ram_wdata_o = '0;
    issue_s     = 1'b0;
    pop_s       = 1'b0;
    push_s      = 1'b0;
    fifo_pop_s  = 1'b0;
    wr_fire_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d   = cmd_write_i ? ST_WRITE : ST_READ;
          addr_d    = cmd_addr_i;
          len_d     = cmd_len_i;
          cnt_d     = '0;
          pop_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wr_ready_o  = (cnt_q < len_q);
        wr_fire_s   = wr_valid_i && wr_ready_o;
        ram_req_o   = wr_fire_s;
        ram_we_o    = wr_fire_s;
        ram_wdata_o = wr_data_i;
        if (wr_fire_s) begin
          addr_d = addr_inc_s;
          cnt_d  = cnt_q + LW'(1);
        end else begin
          addr_d = addr_q;
        end
        if (cnt_q == len_q) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        rd_valid_o = (count_q != 2'd0) || inflight_q;
        rd_data_o  = (count_q != 2'd0) ? fifo_q[rptr_q] : (inflight_q ? ram_rdata_i : '0);
        pop_s      = rd_valid_o && rd_ready_i;
        fifo_pop_s = pop_s && (count_q != 2'd0);
        push_s     = inflight_q && !(pop_s && (count_q == 2'd0));
        issue_s    = (cnt_q < len_q) && ((count_q + {1'b0, inflight_q}) < 2'd2);
        ram_req_o  = issue_s;
        if (issue_s) begin
          addr_d = addr_inc_s;
          cnt_d  = cnt_q + LW'(1);
        end else begin
          addr_d = addr_q;
        end
        if (pop_s) begin
          pop_cnt_d = pop_cnt_q + LW'(1);
        end else begin
          pop_cnt_d = pop_cnt_q;
        end
        if ((len_q == '0) || (pop_s && ((pop_cnt_q + LW'(1)) == len_q))) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      pop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  // Read-return FIFO; in-flight flag marks a read issued in the previous cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_q[wptr_q] <= ram_rdata_i;
        wptr_q         <= ~wptr_q;
      end
      if (fifo_pop_s) rptr_q <= ~rptr_q;
      count_q    <= count_q + {1'b0, push_s} - {1'b0, fifo_pop_s};
      inflight_q <= issue_s;
    end
  end

`ifdef VRF_BURST_PERF_EN
  logic [31:0] perf_q;
  logic        stall_s;

  assign stall_s = ((state_q == ST_READ) && rd_valid_o && !rd_ready_i) ||
                   ((state_q == ST_WRITE) && !wr_valid_i);
  assign perf_stall_cnt_o = perf_q;

  // Saturating stall counter, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= 32'd0;
    end else if (stall_s && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vrf_burst_master.sv
// Directed bench for vrf_burst_master with a behavioural single-port RAM (1-cycle read).
module tb_vrf_burst_master;
  localparam int W = 128;
  localparam int D = 256;

  logic         clk, rst_n, preload;
  logic         cmd_valid, cmd_write, wr_valid, rd_ready;
  logic [7:0]   cmd_addr;
  logic [4:0]   cmd_len;
  logic [W-1:0] wr_data, ram_rdata;
  logic         cmd_ready_o, wr_ready_o, rd_valid_o, done_o, ram_req_o, ram_we_o;
  logic [W-1:0] rd_data_o, ram_wdata_o;
  logic [7:0]   ram_addr_o;
  logic [31:0]  perf;
  logic [W-1:0] mem [D];

  int errs = 0;
  int checks = 0;

  vrf_burst_master dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready), .rd_data_o(rd_data_o),
    .done_o(done_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
`ifdef VRF_BURST_PERF_EN
    , .perf_stall_cnt_o(perf)
`endif
  );

`ifndef VRF_BURST_PERF_EN
  assign perf = 32'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] init_val(input int i);
    return 128'h5000 + W'(i);
  endfunction

  function automatic logic [W-1:0] a_word(input int k);
    return 128'hA0 + W'(k);
  endfunction

  // Expected RAM content once the write burst of A0..A3 to 0x10 has landed.
  function automatic logic [W-1:0] model_word(input logic [7:0] a);
    if (a >= 8'h10 && a <= 8'h13) return a_word(int'(a) - 16);
    return init_val(int'(a));
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < D; i++) mem[i] <= init_val(i);
    end else begin
      if (ram_req_o && ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      if (ram_req_o && !ram_we_o) ram_rdata <= mem[ram_addr_o];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {cmd_ready_o, wr_ready_o, ram_req_o, ram_we_o, rd_valid_o, done_o};
  endfunction

  task automatic chk_reset(input string name);
    chk({name, "_flags"}, W'(flags()), W'(6'b100000));
    chk({name, "_addr"}, W'(ram_addr_o), W'(8'h00));
    chk({name, "_rdata"}, rd_data_o, '0);
    chk({name, "_wdata"}, ram_wdata_o, '0);
    chk({name, "_perf"}, W'(perf), W'(32'd0));
  endtask

  typedef struct {
    logic cv; logic cw; logic [7:0] ca; logic [4:0] cl;
    logic wv; logic [W-1:0] wd; logic rr;
    logic [5:0] ef; logic [7:0] ea; logic [W-1:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic cv, input logic cw, input logic [7:0] ca,
                              input logic [4:0] cl, input logic wv, input logic [W-1:0] wd,
                              input logic rr, input logic [5:0] ef, input logic [7:0] ea,
                              input logic [W-1:0] ed);
    vec_t v;
    v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd; v.rr = rr;
    v.ef = ef; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  // Read burst driver/monitor: checks request addresses, popped data, request count,
  // outstanding (issued - popped) <= 2 and done with the last pop. Optionally stops early.
  task automatic run_read(input logic [7:0] a, input logic [4:0] l, input bit toggle,
                          input int stop_after);
    int npop = 0, nreq = 0, outst = 0, maxo = 0, done_pop = -1;
    logic [7:0] ea;
    bit pop;
    ea = a;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l; rd_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 80; c++) begin
      rd_ready = toggle ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      #1;
      pop = rd_valid_o && rd_ready;
      if (ram_req_o) begin
        chk("rd_req_addr", W'(ram_addr_o), W'(ea));
        chk("rd_req_we", W'(ram_we_o), W'(1'b0));
        ea = ea + 8'd1;
        nreq++;
      end
      if (pop) begin
        chk("rd_data", rd_data_o, model_word(a + 8'(npop)));
        npop++;
      end
      outst = outst + int'(ram_req_o) - int'(pop);
      if (outst > maxo) maxo = outst;
      if (done_o) done_pop = npop;
      if (stop_after != 0 && npop == stop_after) break;
      if (done_o) break;
      @(negedge clk);
    end
    if (stop_after == 0) begin
      chk("rd_req_count", W'(nreq), W'(l));
      chk("rd_outstanding_gt2", W'(maxo > 2), W'(1'b0));
      chk("rd_done_at_last_pop", W'(done_pop), W'(l));
    end
    @(negedge clk);
    if (stop_after == 0) chk("rd_idle_after", W'(cmd_ready_o), W'(1'b1));
  endtask

  vec_t tbl [14];

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_len = 5'd0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    // Write burst 0x10 len 4, then read it back with rd_ready held high.
    tbl[0]  = mk(1'b1, 1'b1, 8'h10, 5'd4, 1'b0, '0,        1'b0, 6'b100000, 8'h00, '0);
    tbl[1]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b1, a_word(0), 1'b0, 6'b011100, 8'h10, '0);
    tbl[2]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b1, a_word(1), 1'b0, 6'b011100, 8'h11, '0);
    tbl[3]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b1, a_word(2), 1'b0, 6'b011100, 8'h12, '0);
    tbl[4]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b1, a_word(3), 1'b0, 6'b011100, 8'h13, '0);
    tbl[5]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b0, 6'b000001, 8'h00, '0);
    tbl[6]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b0, 6'b100000, 8'h00, '0);
    tbl[7]  = mk(1'b1, 1'b0, 8'h10, 5'd4, 1'b0, '0,        1'b1, 6'b100000, 8'h00, '0);
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b1, 6'b001000, 8'h10, '0);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b1, 6'b001010, 8'h11, a_word(0));
    tbl[10] = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b1, 6'b001010, 8'h12, a_word(1));
    tbl[11] = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b1, 6'b001010, 8'h13, a_word(2));
    tbl[12] = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b1, 6'b000011, 8'h00, a_word(3));
    tbl[13] = mk(1'b0, 1'b0, 8'h00, 5'd0, 1'b0, '0,        1'b1, 6'b100000, 8'h00, '0);

    repeat (2) @(negedge clk);
    #1 chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1; preload = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      cmd_valid = tbl[i].cv; cmd_write = tbl[i].cw; cmd_addr = tbl[i].ca; cmd_len = tbl[i].cl;
      wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_ready = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d_flags", i), W'(flags()), W'(tbl[i].ef));
      if (tbl[i].ef[3]) chk($sformatf("vec%0d_addr", i), W'(ram_addr_o), W'(tbl[i].ea));
      if (tbl[i].ef[3] && tbl[i].ef[2]) chk($sformatf("vec%0d_wdata", i), ram_wdata_o, tbl[i].wd);
      if (tbl[i].ef[1]) chk($sformatf("vec%0d_rdata", i), rd_data_o, tbl[i].ed);
      @(negedge clk);
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;

    run_read(8'h10, 5'd8, 1'b1, 0);   // backpressure 1,0,0,1,...
    run_read(8'hFE, 5'd4, 1'b0, 0);   // address wrap 254,255,0,1

    // Zero-length commands for both directions.
    for (int w = 0; w < 2; w++) begin
      cmd_valid = 1'b1; cmd_write = w[0]; cmd_addr = 8'h30; cmd_len = 5'd0;
      #1 chk("len0_accept", W'(cmd_ready_o), W'(1'b1));
      @(negedge clk);
      cmd_valid = 1'b0;
      #1 chk("len0_done", W'({ram_req_o, done_o}), W'(2'b01));
      @(negedge clk);
      #1 chk("len0_idle", W'({cmd_ready_o, ram_req_o, done_o}), W'(3'b100));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a read burst after three pops.
    run_read(8'h10, 5'd8, 1'b0, 3);
    rst_n = 1'b0;
    #1 chk_reset("midburst_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset_ready", W'(flags()), W'(6'b100000));
    @(negedge clk);

`ifdef VRF_BURST_PERF_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_len = 5'd2; rd_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rd_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (done_o) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1 chk("perf_stall_cnt", W'(perf), W'(32'd5));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
